// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared state encoding, ALU op codes and widths for the ALU share arbiter
package alu_share_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int DW  = 4;
    localparam int OPW = 3;
    localparam int CW  = 4;

    localparam logic [OPW-1:0] OP_ADD = 3'd0;
    localparam logic [OPW-1:0] OP_SUB = 3'd1;
    localparam logic [OPW-1:0] OP_AND = 3'd2;
    localparam logic [OPW-1:0] OP_OR  = 3'd3;
    localparam logic [OPW-1:0] OP_XOR = 3'd4;
    localparam logic [OPW-1:0] OP_NOT = 3'd5;
    localparam logic [OPW-1:0] OP_SHL = 3'd6;
    localparam logic [OPW-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    int  j;
    logic found;

    // walk ptr, ptr+1, ... modulo NREQ and take the first set request
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (en && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 4-bit ALU with a tagged valid/ready response
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_op,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [2:0]        alu_sel,
    input  logic [3:0]        alu_result,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_data,
    output logic              rsp_carry,
    output logic              busy
);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            gnt_any;

    // grants are only offered from IDLE and never while reset is held
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (state == IDLE && rst_n),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign req_ready = gnt;
    assign gnt_any   = |gnt;

    // issue FSM: latch winner onto the ALU, wait the settle window, hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    alu_a   <= req_a[DW*int'(gnt_idx) +: DW];
                    alu_b   <= req_b[DW*int'(gnt_idx) +: DW];
                    alu_sel <= req_op[OPW*int'(gnt_idx) +: OPW];
                    rsp_id  <= gnt_idx;
                    cnt     <= CW'(EXEC_CYCLES - 1);
                    rr_ptr  <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                    busy    <= 1'b1;
                    state   <= EXEC;
                end
                EXEC: if (cnt == '0) begin
                    rsp_data  <= alu_result;
                    rsp_carry <= alu_carry;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
